// File: rtl/non_res_div_host.sv
// Host-side sequencer for the byte-serial non-restoring divider, exposing valid/ready operand and result ports.
// Define DIV_HOST_ZERO_CHECK_EN to answer zero-divisor requests locally without touching the divider.
module non_res_div_host #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        res_timeout,
  output logic        res_div0,
  output logic        div_begin,
  output logic [7:0]  div_in_bus,
  input  logic        div_fin,
  input  logic [7:0]  div_out_bus
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_SEND_HI, S_SEND_LO, S_SEND_DIV, S_WAIT, S_CAP_R, S_DONE
  } state_t;

  state_t        state, next_state;
  logic [15:0]   dividend_q;
  logic [7:0]    divisor_q;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          zero_div;

  assign accept = op_valid && op_ready;

`ifdef DIV_HOST_ZERO_CHECK_EN
  assign zero_div = (divisor == 8'h00);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (accept) next_state = zero_div ? S_DONE : S_BEGIN;
      S_BEGIN:    next_state = S_SEND_HI;
      S_SEND_HI:  next_state = S_SEND_LO;
      S_SEND_LO:  next_state = S_SEND_DIV;
      S_SEND_DIV: next_state = S_WAIT;
      S_WAIT: begin
        if (div_fin)                    next_state = S_CAP_R;
        else if (wait_cnt == CNT_LAST)  next_state = S_DONE;
      end
      S_CAP_R:    next_state = S_DONE;
      S_DONE:     if (res_ready) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_ready    <= 1'b0;
      res_valid   <= 1'b0;
      div_begin   <= 1'b0;
      div_in_bus  <= 8'h00;
      quotient    <= 8'h00;
      remainder   <= 8'h00;
      res_timeout <= 1'b0;
      res_div0    <= 1'b0;
      dividend_q  <= 16'h0000;
      divisor_q   <= 8'h00;
      wait_cnt    <= '0;
    end else begin
      op_ready  <= (next_state == S_IDLE);
      res_valid <= (next_state == S_DONE);
      div_begin <= (next_state == S_BEGIN);

      case (next_state)
        S_SEND_HI:  div_in_bus <= dividend_q[15:8];
        S_SEND_LO:  div_in_bus <= dividend_q[7:0];
        S_SEND_DIV: div_in_bus <= divisor_q;
        default:    div_in_bus <= 8'h00;
      endcase

      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            dividend_q  <= dividend;
            divisor_q   <= divisor;
            res_timeout <= 1'b0;
            res_div0    <= zero_div;
            if (zero_div) begin
              quotient  <= 8'hFF;
              remainder <= dividend[7:0];
            end
          end
        end
        S_WAIT: begin
          if (div_fin) begin
            quotient <= div_out_bus;
          end else if (wait_cnt == CNT_LAST) begin
            res_timeout <= 1'b1;
            quotient    <= 8'h00;
            remainder   <= 8'h00;
          end
        end
        // The divider presents the remainder the cycle after the quotient strobe.
        S_CAP_R: remainder <= div_out_bus;
        S_DONE: begin
          if (res_ready) begin
            res_timeout <= 1'b0;
            res_div0    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_non_res_div_host.sv
// Bench for non_res_div_host: a behavioural divider answers the byte protocol, results compared to plain arithmetic.
// Expectations follow DIV_HOST_ZERO_CHECK_EN when it is defined for the build.
module tb_non_res_div_host;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] dividend = 16'h0000;
  logic [7:0]  divisor = 8'h00;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        res_timeout;
  logic        res_div0;
  logic        div_begin;
  logic [7:0]  div_in_bus;
  logic        div_fin = 1'b0;
  logic [7:0]  div_out_bus = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] dividend;
    logic [7:0]  divisor;
    int          fin_n;
    int          hold;
    int          spur;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        tmo;
    logic        d0;
    int          valid_cyc;
    int          n_begin;
  } vec_t;

  non_res_div_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .dividend(dividend), .divisor(divisor),
    .res_valid(res_valid), .res_ready(res_ready),
    .quotient(quotient), .remainder(remainder),
    .res_timeout(res_timeout), .res_div0(res_div0),
    .div_begin(div_begin), .div_in_bus(div_in_bus),
    .div_fin(div_fin), .div_out_bus(div_out_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // What an ideal divider returns: truncated quotient byte, true remainder; all-ones on a zero divisor.
  function automatic void div_ref(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r);
    int unsigned qq;
    if (b == 8'h00) begin
      q = 8'hFF;
      r = a[7:0];
    end else begin
      qq = 32'(a / b);
      q  = qq[7:0];
      r  = 8'(a % b);
    end
  endfunction

  function automatic vec_t make_vec(input logic [15:0] a, input logic [7:0] b,
                                    input int fin_n, input int hold, input int spur);
    vec_t v;
    v.dividend = a; v.divisor = b; v.fin_n = fin_n; v.hold = hold; v.spur = spur;
    v.tmo = 1'b0; v.d0 = 1'b0; v.n_begin = 1;
`ifdef DIV_HOST_ZERO_CHECK_EN
    if (b == 8'h00) begin
      v.q = 8'hFF; v.r = a[7:0]; v.d0 = 1'b1; v.n_begin = 0; v.valid_cyc = 1;
      return v;
    end
`endif
    if (fin_n < 5 || fin_n > 4 + TMO) begin
      v.q = 8'h00; v.r = 8'h00; v.tmo = 1'b1; v.valid_cyc = 5 + TMO;
    end else begin
      div_ref(a, b, v.q, v.r);
      v.valid_cyc = fin_n + 2;
    end
    return v;
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_op_ready"}, op_ready, 0);
    checkOutput({tag, "_res_valid"}, res_valid, 0);
    checkOutput({tag, "_div_begin"}, div_begin, 0);
    checkOutput({tag, "_div_in_bus"}, div_in_bus, 0);
    checkOutput({tag, "_quotient"}, quotient, 0);
    checkOutput({tag, "_remainder"}, remainder, 0);
    checkOutput({tag, "_timeout"}, res_timeout, 0);
    checkOutput({tag, "_div0"}, res_div0, 0);
  endtask

  // One full transaction; the divider model lives inline, collecting the bytes that follow div_begin.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] obs_bytes [3];
    logic [7:0] mq, mr;
    int c, nb, begin_cnt, begin_at, valid_cyc;
    bit bus_idle_ok, busy_ok, stable_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    mq = 8'($urandom); mr = 8'($urandom);
    c = 0;
    while (!op_ready && c < 20) begin tick(); c++; end
    checkOutput({tag, "_op_ready_idle"}, op_ready, 1);

    op_valid = 1'b1; dividend = v.dividend; divisor = v.divisor;
    tick();
    op_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);

    c = 1; nb = 0; begin_cnt = 0; begin_at = -1; valid_cyc = -1;
    bus_idle_ok = 1'b1; busy_ok = 1'b1;
    while (valid_cyc < 0 && c <= 200) begin
      if (res_valid) begin
        valid_cyc = c;
      end else begin
        if (op_ready) busy_ok = 1'b0;
        if (div_begin) begin
          begin_cnt++; begin_at = c; nb = 0;
        end else if (begin_at > 0 && nb < 3) begin
          obs_bytes[nb] = div_in_bus;
          nb++;
          if (nb == 3) div_ref({obs_bytes[0], obs_bytes[1]}, obs_bytes[2], mq, mr);
        end else if (begin_at > 0 && div_in_bus != 8'h00) begin
          bus_idle_ok = 1'b0;
        end
        div_fin = 1'b0;
        div_out_bus = 8'($urandom);
        if (c == v.spur) div_fin = 1'b1;
        if (c == v.fin_n) begin
          div_fin = 1'b1; div_out_bus = mq;
        end else if (v.fin_n > 0 && c == v.fin_n + 1) begin
          div_out_bus = mr;
        end
        tick();
        c++;
      end
    end
    div_fin = 1'b0;

    checkOutput({tag, "_valid_cycle"}, valid_cyc, v.valid_cyc);
    checkOutput({tag, "_begin_count"}, begin_cnt, v.n_begin);
    if (v.n_begin > 0) begin
      checkOutput({tag, "_begin_cycle"}, begin_at, 1);
      checkOutput({tag, "_bytes_seen"}, nb, 3);
      checkOutput({tag, "_byte_hi"}, obs_bytes[0], v.dividend[15:8]);
      checkOutput({tag, "_byte_lo"}, obs_bytes[1], v.dividend[7:0]);
      checkOutput({tag, "_byte_div"}, obs_bytes[2], v.divisor);
      checkOutput({tag, "_bus_idle_wait"}, bus_idle_ok, 1);
      checkOutput({tag, "_op_ready_busy"}, busy_ok, 1);
    end
    checkOutput({tag, "_quotient"}, quotient, v.q);
    checkOutput({tag, "_remainder"}, remainder, v.r);
    checkOutput({tag, "_timeout"}, res_timeout, v.tmo);
    checkOutput({tag, "_div0"}, res_div0, v.d0);

    stable_ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      if (!res_valid || op_ready || quotient !== v.q || remainder !== v.r ||
          res_timeout !== v.tmo || res_div0 !== v.d0)
        stable_ok = 1'b0;
    end
    if (v.hold > 0) checkOutput({tag, "_hold_stable"}, stable_ok, 1);

    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_op_ready_after"}, op_ready, 1);
    checkOutput({tag, "_valid_cleared"}, res_valid, 0);
    checkOutput({tag, "_timeout_cleared"}, res_timeout, 0);
    checkOutput({tag, "_div0_cleared"}, res_div0, 0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [7:0] rnd_div;

    vecs.push_back('{16'h1FA9, 8'h4F, 12, 0, 0, 8'h66, 8'h2F, 1'b0, 1'b0, 14, 1});
    vecs.push_back('{16'h1FA9, 8'h4F, 12, 10, 0, 8'h66, 8'h2F, 1'b0, 1'b0, 14, 1});
    vecs.push_back('{16'h1234, 8'h56, 0, 2, 0, 8'h00, 8'h00, 1'b1, 1'b0, 5 + TMO, 1});
    vecs.push_back(make_vec(16'h0123, 8'h00, 7, 1, 0));
    vecs.push_back(make_vec(16'h1FA9, 8'h4F, 9, 0, 3));
    vecs.push_back(make_vec(16'hFF00, 8'h10, 4 + TMO, 0, 0));
    vecs.push_back(make_vec(16'h4321, 8'h07, 5 + TMO, 0, 0));
    vecs.push_back(make_vec(16'h0005, 8'h09, 5, 0, 0));
    for (int i = 0; i < 8; i++) begin
      rnd_div = 8'($urandom_range(0, 255));
      vecs.push_back(make_vec(16'($urandom), rnd_div, $urandom_range(5, 14),
                              $urandom_range(0, 3), $urandom_range(0, 4)));
    end

    #2;
    checkReset("por");
    tick(); tick();
    rst = 1'b1;
    tick();
    checkOutput("op_ready_after_reset", op_ready, 1);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Abort a transaction while it sits in WAIT, then show the host recovers cleanly.
    op_valid = 1'b1; dividend = 16'hBEEF; divisor = 8'h21;
    tick();
    op_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    checkReset("mid_wait_rst");
    tick();
    checkReset("mid_wait_rst_held");
    rst = 1'b1;
    tick();
    checkOutput("op_ready_after_mid_reset", op_ready, 1);
    applyStimulus(vecs[0], 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/non_res_div_host.md
# non_res_div_host

Host-side sequencer for the byte-serial non-restoring divider. It accepts a 16-bit dividend and an 8-bit divisor on a parallel valid/ready interface. It drives the divider's start pulse and three operand bytes, then waits for `fin` and collects the quotient and remainder bytes. It presents the result on a parallel valid/ready interface, so that a datapath or bus slave can use the divider without knowing its byte protocol.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in WAIT before the transaction is aborted with `res_timeout`.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `op_valid` in 1: operand request.
- `op_ready` out 1: host is idle and can accept operands.
- `dividend` in 16: dividend, sampled at accept.
- `divisor` in 8: divisor, sampled at accept.
- `res_valid` out 1: result held valid until consumed.
- `res_ready` in 1: consumer accepts the result.
- `quotient` out 8: captured quotient.
- `remainder` out 8: captured remainder.
- `res_timeout` out 1: the result is an aborted transaction.
- `res_div0` out 1: divisor was zero (only when `DIV_HOST_ZERO_CHECK_EN` is defined; otherwise tied 0).
- `div_begin` out 1: start pulse to the divider.
- `div_in_bus` out 8: operand byte to the divider.
- `div_fin` in 1: divider result strobe.
- `div_out_bus` in 8: divider result byte.

## Operation
- States: IDLE, BEGIN, SEND_HI, SEND_LO, SEND_DIV, WAIT, CAP_R, DONE.
- IDLE
  - `op_ready`=1.
  - On `op_valid && op_ready`, latch `dividend` and `divisor`, then go to BEGIN.
- BEGIN: `div_begin`=1, `div_in_bus`=0, then go to SEND_HI.
- SEND_HI: `div_in_bus`=dividend[15:8].
- SEND_LO: `div_in_bus`=dividend[7:0].
- SEND_DIV: `div_in_bus`=divisor, then go to WAIT.
- WAIT
  - `div_in_bus`=0.
  - The timeout counter clears on entry and increments every cycle.
  - If `div_fin`=1 is sampled, capture `div_out_bus` into `quotient` and go to CAP_R.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, set `res_timeout`=1, `quotient`=`remainder`=0, and go to DONE.
- CAP_R: capture `div_out_bus` into `remainder` and go to DONE. The divider presents the remainder on the cycle after the quotient.
- DONE
  - `res_valid`=1; `quotient`, `remainder` and flags are held stable.
  - On `res_ready`=1, go to IDLE and clear the flags. Stall indefinitely while `res_ready`=0.
- `div_fin` outside WAIT/CAP_R is ignored.
- No arithmetic is performed locally. Quotient overflow (dividend[15:8] ≥ divisor) is passed through as whatever the divider returns.
- Reset (any state, asynchronous)
  - State goes to IDLE.
  - All outputs are 0, except `op_ready`, which is 1 after reset is released.
  - Latched operands, results and flags clear to 0.
  - A divider transaction in flight is abandoned; the next `div_begin` restarts it.

## Timing
- Accept edge = cycle 0.
- `div_begin` is high for exactly cycle 1.
- Bytes on cycles 2, 3, 4 (high, low, divisor); `div_in_bus`=0 from cycle 5.
- If `div_fin` is first high in cycle N (N≥5): quotient captured at the end of N, remainder at the end of N+1, `res_valid` high from cycle N+2.
- The result handshake completes at the edge where `res_valid && res_ready`. `op_ready` is high the following cycle, so back-to-back issue costs one idle cycle.
- Timeout: with no `div_fin`, `res_valid` rises at cycle 5+`TIMEOUT_CYCLES`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DIV_HOST_ZERO_CHECK_EN` defined
  - At accept, if `divisor`==0, go directly IDLE→DONE.
  - No `div_begin` is issued.
  - `quotient`=8'hFF, `remainder`=dividend[7:0], `res_div0`=1.
  - `res_valid` is high on cycle 1.
- Not defined: a zero divisor is sent to the divider like any other value, and `res_div0` is constant 0.

## Test plan
- Reset low mid-WAIT → next cycle IDLE, all outputs 0; after release `op_ready`=1 and a new op runs normally.
- dividend=16'h1FA9, divisor=8'h4F, behavioral divider raising `fin` at N=12 → `div_begin` on cycle 1; bytes 1F, A9, 4F on cycles 2–4; `quotient`=8'h66, `remainder`=8'h2F; `res_valid` at cycle 14.
- Same op with `res_ready` held 0 for 10 cycles → outputs stable throughout and `op_ready`=0; release → IDLE one cycle later.
- Divider never asserts `fin`, `TIMEOUT_CYCLES`=16 → `res_valid` at cycle 21 with `res_timeout`=1, `quotient`=`remainder`=0.
- divisor=0, dividend=16'h0123: with the macro → no `div_begin`, `quotient`=FF, `remainder`=23, `res_div0`=1 on cycle 1. Without the macro → full byte sequence is sent and `res_div0`=0.
- Spurious `div_fin` pulse during SEND_LO → ignored; capture occurs only at the WAIT-state `fin`.
